// File: rtl/stream_demux_pkg.sv
// stream_demux_pkg: shared state type and drop-counter constants for stream_demux_n
package stream_demux_pkg;
  typedef enum logic {EMPTY, FULL} demux_state_t;
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: gated index-to-one-hot decode with selectable output polarity
module onehot_decoder #(
  parameter int N = 8,
  parameter bit ACTIVE_LOW = 0,
  localparam int SW = $clog2(N)
) (
  input  logic [SW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  dec
);
  logic [N-1:0] oh;
  always_comb begin
    oh = en ? N'(1) << idx : '0;
    dec = ACTIVE_LOW ? ~oh : oh;
  end
endmodule

// File: rtl/stream_demux_n.sv
// stream_demux_n: registered 1-to-N valid/ready demux with one-hot channel decode and drop counter
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH = 8,
  parameter bit ACTIVE_LOW = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [N_CH-1:0]   out_valid,
  input  logic [N_CH-1:0]   out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [N_CH-1:0]   dec_n,
  output logic [DROP_W-1:0] drop_cnt
);
  demux_state_t state, state_nx;
  logic [DATA_W-1:0] hold_data;
  logic [SEL_W-1:0] hold_sel;
  logic full, out_fire, in_fire, sel_ok, load;
  // out_valid is already the one-hot of hold_sel, so this picks out_ready[hold_sel]
  always_comb begin
    full = state == FULL;
    out_fire = |(out_valid & out_ready);
    in_ready = !full || out_fire;
    in_fire = in_valid && in_ready;
    sel_ok = 32'(in_sel) < N_CH;
    load = in_fire && sel_ok;
    state_nx = load ? FULL : out_fire ? EMPTY : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= EMPTY;
      hold_data <= '0;
      hold_sel <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        hold_data <= in_data;
        hold_sel <= in_sel;
      end
      if (in_fire && !sel_ok && drop_cnt != DROP_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  assign out_data = hold_data;
  onehot_decoder #(.N(N_CH), .ACTIVE_LOW(0)) u_valid (.idx(hold_sel), .en(full), .dec(out_valid));
  onehot_decoder #(.N(N_CH), .ACTIVE_LOW(ACTIVE_LOW)) u_dec (.idx(hold_sel), .en(full), .dec(dec_n));
endmodule

// File: tb/tb_stream_demux_n.sv
// tb_stream_demux_n: directed checks of an 8-channel active-low and a 5-channel active-high demux against a slot model
module tb_stream_demux_n;
  logic clk = 0;
  logic rst_n;
  logic go = 0;
  int tests = 0;
  int fails = 0;
  logic [1:0] iv;
  logic [7:0] id[2];
  logic [2:0] is[2];
  logic [7:0] ordy[2];
  logic ir8, ir5;
  logic [7:0] ov8, od8, dn8, dc8, od5, dc5;
  logic [4:0] ov5, dn5;
  logic [7:0] a_ov[2], a_od[2], a_dn[2], a_dc[2];
  logic a_ir[2];
  int m_full[2], m_sel[2], m_data[2], m_cnt[2];
  always #5 clk = ~clk;

  stream_demux_n #(.DATA_W(8), .N_CH(8), .ACTIVE_LOW(1)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir8), .in_data(id[0]), .in_sel(is[0]),
    .out_valid(ov8), .out_ready(ordy[0]), .out_data(od8), .dec_n(dn8), .drop_cnt(dc8));
  stream_demux_n #(.DATA_W(8), .N_CH(5), .ACTIVE_LOW(0)) d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir5), .in_data(id[1]), .in_sel(is[1]),
    .out_valid(ov5), .out_ready(ordy[1][4:0]), .out_data(od5), .dec_n(dn5), .drop_cnt(dc5));

  assign a_ov[0] = ov8;
  assign a_ov[1] = {3'b0, ov5};
  assign a_dn[0] = dn8;
  assign a_dn[1] = {3'b0, dn5};
  assign a_od[0] = od8;
  assign a_od[1] = od5;
  assign a_dc[0] = dc8;
  assign a_dc[1] = dc5;
  assign a_ir[0] = ir8;
  assign a_ir[1] = ir5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // Model: a single holding slot per DUT; output side frees it, input side may refill it the same edge.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_full[k] <= 0;
        m_sel[k] <= 0;
        m_data[k] <= 0;
        m_cnt[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int n;
        bit took, taken;
        n = k ? 5 : 8;
        taken = m_full[k] != 0 && ordy[k][m_sel[k]];
        took = iv[k] && (m_full[k] == 0 || taken);
        if (took && is[k] < n) begin
          m_full[k] <= 1;
          m_sel[k] <= int'(is[k]);
          m_data[k] <= int'(id[k]);
        end else if (taken) m_full[k] <= 0;
        if (took && is[k] >= n) m_cnt[k] <= m_cnt[k] >= 255 ? 255 : m_cnt[k] + 1;
      end
    end

  always @(negedge clk)
    if (go)
      for (int k = 0; k < 2; k++) begin
        logic [7:0] e_ov, e_dn;
        logic e_ir;
        e_ov = m_full[k] != 0 ? 8'd1 << m_sel[k] : 8'd0;
        e_dn = k == 0 ? ~e_ov : e_ov;
        e_ir = m_full[k] == 0 || ordy[k][m_sel[k]];
        chk($sformatf("d%0d out_valid", k), a_ov[k], e_ov);
        chk($sformatf("d%0d dec_n", k), a_dn[k], e_dn);
        chk($sformatf("d%0d in_ready", k), a_ir[k], e_ir);
        chk($sformatf("d%0d drop_cnt", k), a_dc[k], m_cnt[k]);
        if (m_full[k] != 0) chk($sformatf("d%0d out_data", k), a_od[k], m_data[k]);
      end

  initial begin
    rst_n = 0;
    iv = '0;
    for (int k = 0; k < 2; k++) begin
      id[k] = 0;
      is[k] = 0;
      ordy[k] = 0;
    end
    cyc;
    cyc;
    go = 1;
    rst_n = 1;
    chk("rst out_valid", ov8, 8'h00);
    chk("rst dec_n", dn8, 8'hFF);
    chk("rst in_ready", ir8, 1);
    chk("rst out_data", od8, 8'h00);
    // reset mid-transfer
    iv[0] = 1; id[0] = 8'h5A; is[0] = 3;
    cyc;
    iv[0] = 0;
    chk("held out_valid", ov8, 8'h08);
    chk("held dec_n", dn8, 8'hF7);
    chk("held out_data", od8, 8'h5A);
    #2 rst_n = 0;
    #1;
    chk("midrst out_valid", ov8, 8'h00);
    chk("midrst dec_n", dn8, 8'hFF);
    chk("midrst out_data", od8, 8'h00);
    chk("midrst drop_cnt", dc8, 8'h00);
    #2 rst_n = 1;
    #1 chk("midrst in_ready", ir8, 1);
    cyc;
    // basic routing at full rate
    ordy[0] = 8'hFF;
    iv[0] = 1; id[0] = 8'h11; is[0] = 0;
    cyc;
    chk("route0 out_valid", ov8, 8'h01);
    chk("route0 dec_n", dn8, 8'hFE);
    chk("route0 out_data", od8, 8'h11);
    id[0] = 8'h22; is[0] = 5;
    cyc;
    chk("route5 out_valid", ov8, 8'h20);
    chk("route5 dec_n", dn8, 8'hDF);
    chk("route5 out_data", od8, 8'h22);
    id[0] = 8'h33; is[0] = 7;
    cyc;
    chk("route7 out_valid", ov8, 8'h80);
    chk("route7 dec_n", dn8, 8'h7F);
    chk("route7 out_data", od8, 8'h33);
    iv[0] = 0;
    cyc;
    chk("route drain", ov8, 8'h00);
    // back-pressure on channel 2, channel 6 ready must be ignored
    ordy[0] = 8'h40;
    iv[0] = 1; id[0] = 8'hA5; is[0] = 2;
    cyc;
    id[0] = 8'hB6; is[0] = 1;
    for (int i = 0; i < 4; i++) begin
      chk("bp in_ready", ir8, 0);
      chk("bp out_valid", ov8, 8'h04);
      chk("bp out_data", od8, 8'hA5);
      cyc;
    end
    ordy[0] = 8'h44;
    #1 chk("bp release in_ready", ir8, 1);
    cyc;
    chk("bp next out_valid", ov8, 8'h02);
    chk("bp next out_data", od8, 8'hB6);
    iv[0] = 0; ordy[0] = 8'hFF;
    cyc;
    chk("bp drain", ov8, 8'h00);
    // five channels, active-high decode
    iv[1] = 1; id[1] = 8'h77; is[1] = 6;
    cyc;
    iv[1] = 0;
    chk("n5 drop out_valid", ov5, 5'b00000);
    chk("n5 drop cnt", dc5, 8'd1);
    chk("n5 drop in_ready", ir5, 1);
    iv[1] = 1; id[1] = 8'h44; is[1] = 4;
    cyc;
    iv[1] = 0;
    chk("n5 ch4 out_valid", ov5, 5'b10000);
    chk("n5 ch4 dec_n", dn5, 5'b10000);
    chk("n5 ch4 out_data", od5, 8'h44);
    cyc;
    chk("n5 ch4 stall", ov5, 5'b10000);
    // output handshake coinciding with a dropped beat
    ordy[1] = 8'h10;
    iv[1] = 1; id[1] = 8'h99; is[1] = 7;
    #1 chk("n5 sim in_ready", ir5, 1);
    cyc;
    iv[1] = 0;
    chk("n5 sim out_valid", ov5, 5'b00000);
    chk("n5 sim drop_cnt", dc5, 8'd2);
    // drop-counter saturation
    iv[1] = 1; is[1] = 5;
    for (int i = 0; i < 300; i++) begin
      id[1] = 8'(i);
      cyc;
    end
    iv[1] = 0;
    chk("n5 sat drop_cnt", dc5, 8'd255);
    chk("n5 sat out_valid", ov5, 5'b00000);
    cyc;
    cyc;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
